// File: rtl/gray_counter_param.sv
// gray_counter_param: parametrised up/down Gray sequencer with load, wrap/saturate and terminal count.
// Optional GRAY_STEP_CHECK_EN adds a sticky err output flagging any multi-bit gray change on an en step.
module gray_counter_param #(
    parameter int               WIDTH     = 3,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             err
`endif
);
    localparam logic [WIDTH-1:0] MAX = '1;
    logic [WIDTH-1:0] nxt;
    logic             hold_end;
    logic             wrap_nxt;
    always_comb begin
        tc       = up ? bin == MAX : bin == '0;
        hold_end = tc & SATURATE;
        nxt      = load ? load_val : (en & ~hold_end) ? (up ? bin + 1'b1 : bin - 1'b1) : bin;
        wrap_nxt = ~load & en & tc & ~SATURATE;
    end
    // gray is derived from the next binary value so both registers always agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= RESET_VAL;
            gray <= RESET_VAL ^ (RESET_VAL >> 1);
            wrap <= 1'b0;
        end else begin
            bin  <= nxt;
            gray <= nxt ^ (nxt >> 1);
            wrap <= wrap_nxt;
        end
    end
`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] diff;
    logic             stepped;
    always_comb diff = gray ^ gray_q;
    // stepped marks that the current gray came from an en step; loads and reset release leave it low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q  <= RESET_VAL ^ (RESET_VAL >> 1);
            stepped <= 1'b0;
            err     <= 1'b0;
        end else begin
            gray_q  <= gray;
            stepped <= ~load & en;
            err     <= err | (stepped & ((diff & (diff - 1'b1)) != '0));
        end
    end
`endif
endmodule
